// File: rtl/mux4x1_pkg.sv
// Shared select encoding and reset constants for the 4-to-1 datapath selector.
package mux4x1_pkg;

  typedef enum logic [1:0] {
    SEL_D0 = 2'd0,
    SEL_D1 = 2'd1,
    SEL_D2 = 2'd2,
    SEL_D3 = 2'd3
  } sel_t;

  localparam sel_t RESET_SEL = SEL_D0;

endpackage

// File: rtl/mux4x1_out_reg.sv
// Synchronous-reset, enable-gated capture register; 1-cycle latency, holds when enable is low.
module mux4x1_out_reg #(
  parameter int unsigned W = 6,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset takes priority over enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux4x1_n.sv
// BITS-wide 4:1 mux: MUX_OUT is combinational, MUX_OUT_REG/SEL_REG follow one edge later when ENABLE.
// Define MUX4X1_PARITY_EN to add PARITY (combinational) and PARITY_REG outputs.
module mux4x1_n
  import mux4x1_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ENABLE,
  input  logic [BITS-1:0] D3,
  input  logic [BITS-1:0] D2,
  input  logic [BITS-1:0] D1,
  input  logic [BITS-1:0] D0,
  input  logic [1:0]      SEL,
  output logic [BITS-1:0] MUX_OUT,
  output logic [BITS-1:0] MUX_OUT_REG,
  output logic [1:0]      SEL_REG
`ifdef MUX4X1_PARITY_EN
  ,
  output logic            PARITY,
  output logic            PARITY_REG
`endif
);

`ifdef MUX4X1_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif

  localparam int unsigned RW = BITS + 2 + PW;
  localparam logic [RW-1:0] REG_RST = {RESET_SEL, {(BITS + PW){1'b0}}};

  logic [RW-1:0] reg_d;
  logic [RW-1:0] reg_q;

  // An unknown select falls through to the default and yields all-X in simulation.
  always_comb begin
    MUX_OUT = 'x;
    case (sel_t'(SEL))
      SEL_D0:  MUX_OUT = D0;
      SEL_D1:  MUX_OUT = D1;
      SEL_D2:  MUX_OUT = D2;
      SEL_D3:  MUX_OUT = D3;
      default: MUX_OUT = 'x;
    endcase
  end

`ifdef MUX4X1_PARITY_EN
  assign PARITY     = ^MUX_OUT;
  assign reg_d      = {SEL, MUX_OUT, PARITY};
  assign PARITY_REG = reg_q[0];
`else
  assign reg_d      = {SEL, MUX_OUT};
`endif

  assign MUX_OUT_REG = reg_q[PW +: BITS];
  assign SEL_REG     = reg_q[RW-1 -: 2];

  mux4x1_out_reg #(
    .W       (RW),
    .RST_VAL (REG_RST)
  ) u_out_reg (
    .clock  (clock),
    .reset  (reset),
    .enable (ENABLE),
    .d      (reg_d),
    .q      (reg_q)
  );

endmodule

// File: tb/tb_mux4x1_n.sv
// Directed-vector bench for mux4x1_n with hand-computed expectations.
module tb_mux4x1_n;

  localparam int unsigned BITS = 4;

  logic            clock;
  logic            reset;
  logic            enable;
  logic [BITS-1:0] d3, d2, d1, d0;
  logic [1:0]      sel;
  logic [BITS-1:0] mux_out;
  logic [BITS-1:0] mux_out_reg;
  logic [1:0]      sel_reg;
`ifdef MUX4X1_PARITY_EN
  logic            parity;
  logic            parity_reg;
`endif

  int checks   = 0;
  int failures = 0;

  mux4x1_n #(.BITS(BITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .ENABLE      (enable),
    .D3          (d3),
    .D2          (d2),
    .D1          (d1),
    .D0          (d0),
    .SEL         (sel),
    .MUX_OUT     (mux_out),
    .MUX_OUT_REG (mux_out_reg),
    .SEL_REG     (sel_reg)
`ifdef MUX4X1_PARITY_EN
    ,
    .PARITY      (parity),
    .PARITY_REG  (parity_reg)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [3:0] v3, input logic [3:0] v2,
                          input logic [3:0] v1, input logic [3:0] v0);
    d3 = v3; d2 = v2; d1 = v1; d0 = v0;
  endtask

  // Advance past one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sel = 2'b00;
    set_data(4'h0, 4'h0, 4'h0, 4'h0);
    step();
    check("rst_mux_out_reg", 32'(mux_out_reg), 32'h0);
    check("rst_sel_reg", 32'(sel_reg), 32'h0);
    reset = 1'b0;

    // Combinational checks, no clock edge involved.
    #1 check("all_zero_sel00", 32'(mux_out), 32'h0);
    set_data(4'hF, 4'hF, 4'hF, 4'hF); sel = 2'b11;
    #1 check("all_f_sel11", 32'(mux_out), 32'hF);

    set_data(4'h3, 4'h2, 4'h1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1 check($sformatf("sweep_sel%0d", i), 32'(mux_out), 32'(i));
    end

    set_data(4'hE, 4'h2, 4'hC, 4'h5); sel = 2'b00;
    #1 check("e2c5_sel00", 32'(mux_out), 32'h5);
    set_data(4'h5, 4'hB, 4'h5, 4'hB); sel = 2'b11;
    #1 check("5b5b_sel11", 32'(mux_out), 32'h5);
    set_data(4'h1, 4'h2, 4'h3, 4'h4); sel = 2'b00;
    #1 check("1234_sel00", 32'(mux_out), 32'h4);
    sel = 2'b10;
    #1 check("1234_sel10", 32'(mux_out), 32'h2);

    // Registered stage: load a non-zero value, then reset must clear it.
    set_data(4'h3, 4'h2, 4'h1, 4'h0);
    enable = 1'b1; sel = 2'b11;
    step();
    check("load_d3_reg", 32'(mux_out_reg), 32'h3);
    check("load_d3_sel_reg", 32'(sel_reg), 32'h3);
    enable = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_clear_reg", 32'(mux_out_reg), 32'h0);
    check("reset_clear_sel_reg", 32'(sel_reg), 32'h0);

    enable = 1'b1; sel = 2'b10;
    step();
    check("en_sel10_reg", 32'(mux_out_reg), 32'h2);
    check("en_sel10_sel_reg", 32'(sel_reg), 32'h2);

    enable = 1'b0; sel = 2'b11;
    #1 check("hold_mux_out_now", 32'(mux_out), 32'h3);
    step();
    check("hold_reg", 32'(mux_out_reg), 32'h2);
    check("hold_sel_reg", 32'(sel_reg), 32'h2);
    step();
    check("hold_reg_2", 32'(mux_out_reg), 32'h2);

    // Reset and enable on the same edge: reset wins.
    d3 = 4'hF; sel = 2'b11; reset = 1'b1; enable = 1'b1;
    #1 check("rst_en_mux_out_pre", 32'(mux_out), 32'hF);
    step();
    check("rst_en_reg", 32'(mux_out_reg), 32'h0);
    check("rst_en_sel_reg", 32'(sel_reg), 32'h0);
    check("rst_en_mux_out_post", 32'(mux_out), 32'hF);
    reset = 1'b0;
    step();
    check("post_rst_load_reg", 32'(mux_out_reg), 32'hF);
    check("post_rst_load_sel_reg", 32'(sel_reg), 32'h3);

`ifdef MUX4X1_PARITY_EN
    d1 = 4'h7; sel = 2'b01; enable = 1'b0;
    #1 check("parity_d1_7", 32'(parity), 32'h1);
    check("parity_reg_before", 32'(parity_reg), 32'h0);
    enable = 1'b1;
    step();
    check("parity_reg_d1_7", 32'(parity_reg), 32'h1);
    d1 = 4'h3;
    #1 check("parity_d1_3", 32'(parity), 32'h0);
    enable = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("parity_reg_reset", 32'(parity_reg), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
